// File: rtl/dds_param_rx.sv
// dds_param_rx: 96 MHz-side receiver for the REQ/ACK parameter handshake plus the chirp frequency ramp.
// Define DDS_PHASE_ACC_EN to build the phase accumulator on PHASE; otherwise PHASE is tied to 0.
module dds_param_rx #(
  parameter int FREQ_W = 48,
  parameter int RATE_W = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  output logic              ACK,
  input  logic [FREQ_W-1:0] DDS_freq,
  input  logic [FREQ_W-1:0] DDS_delta_freq,
  input  logic [RATE_W-1:0] DDS_delta_rate,
  input  logic              start,
  output logic              LOAD,
  output logic              RUN,
  output logic [FREQ_W-1:0] FREQ_CUR,
  output logic [FREQ_W-1:0] PHASE
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] req_sync, start_sync;
  logic req_s, start_s, start_q, start_rise, capture, last;
  logic [FREQ_W-1:0] sh_freq, sh_step, run_step, base_freq, base_step;
  logic [RATE_W-1:0] sh_rate, run_rate, base_rate, rate_cnt;
  assign req_s = req_sync[SYNC_STAGES-1];
  assign start_s = start_sync[SYNC_STAGES-1];
  assign start_rise = start_s & ~start_q;
  // a capture landing on the same edge as the start edge feeds the ramp directly
  assign base_freq = capture ? DDS_freq : sh_freq;
  assign base_step = capture ? DDS_delta_freq : sh_step;
  assign base_rate = capture ? DDS_delta_rate : sh_rate;
  assign last = run_rate != '0 && rate_cnt == run_rate - 1'b1;
  always_comb begin
    capture = state == IDLE && req_s;
    state_nxt = capture ? HOLD : (state == HOLD && !req_s) ? IDLE : state;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req_sync <= '0;
      start_sync <= '0;
      start_q <= 1'b0;
      state <= IDLE;
      ACK <= 1'b0;
      LOAD <= 1'b0;
      sh_freq <= '0;
      sh_step <= '0;
      sh_rate <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], REQ};
      start_sync <= {start_sync[SYNC_STAGES-2:0], start};
      start_q <= start_s;
      state <= state_nxt;
      ACK <= state_nxt == HOLD;
      LOAD <= capture;
      if (capture) begin
        sh_freq <= DDS_freq;
        sh_step <= DDS_delta_freq;
        sh_rate <= DDS_delta_rate;
      end
    end
  end
  // the running ramp keeps its own step/rate so mid-run captures only touch the shadows
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RUN <= 1'b0;
      FREQ_CUR <= '0;
      run_step <= '0;
      run_rate <= '0;
      rate_cnt <= '0;
    end else if (start_rise) begin
      RUN <= 1'b1;
      FREQ_CUR <= base_freq;
      run_step <= base_step;
      run_rate <= base_rate;
      rate_cnt <= '0;
    end else if (!start_s) begin
      RUN <= 1'b0;
      FREQ_CUR <= '0;
      rate_cnt <= '0;
    end else if (RUN) begin
      rate_cnt <= (run_rate == '0 || last) ? '0 : rate_cnt + 1'b1;
      if (last) FREQ_CUR <= FREQ_CUR + run_step;
    end
  end
`ifdef DDS_PHASE_ACC_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) PHASE <= '0;
    else if (start_rise || !start_s) PHASE <= '0;
    else if (RUN) PHASE <= PHASE + FREQ_CUR;
  end
`else
  assign PHASE = '0;
`endif
endmodule

// File: tb/tb_dds_param_rx.sv
// tb_dds_param_rx: directed bench with a cycle-level behavioural model of the receiver and ramp.
module tb_dds_param_rx;
  localparam int FW = 48;
  localparam int RW = 32;
  localparam int S = 2;
  logic CLK = 1'b0, RESET = 1'b1, REQ = 1'b0, start = 1'b0;
  logic [FW-1:0] DDS_freq = '0, DDS_delta_freq = '0;
  logic [RW-1:0] DDS_delta_rate = '0;
  logic ACK, LOAD, RUN;
  logic [FW-1:0] FREQ_CUR, PHASE;
  int vectors = 0, errors = 0;

  dds_param_rx #(.FREQ_W(FW), .RATE_W(RW), .SYNC_STAGES(S)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .ACK(ACK),
    .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq), .DDS_delta_rate(DDS_delta_rate),
    .start(start), .LOAD(LOAD), .RUN(RUN), .FREQ_CUR(FREQ_CUR), .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // Behavioural model: inputs seen through an S-cycle delay line, one capture per request,
  // ramp value = base + step * floor(cycles_since_start / rate).
  bit qr[S], qs[S];
  bit rs, ss, m_busy, m_ack, m_load, m_run, m_ps;
  logic [FW-1:0] sh_f, sh_s, m_base, m_step, m_phase, cur;
  logic [RW-1:0] sh_r, m_rate;
  int n;

  function automatic logic [FW-1:0] exp_freq();
    if (!m_run) return '0;
    if (m_rate == 0) return m_base;
    return m_base + m_step * (n / m_rate);
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < S; i++) begin qr[i] = 0; qs[i] = 0; end
      m_busy = 0; m_ack = 0; m_load = 0; m_run = 0; m_ps = 0; n = 0;
      sh_f = '0; sh_s = '0; sh_r = '0; m_base = '0; m_step = '0; m_rate = '0; m_phase = '0;
    end else begin
      rs = qr[S-1];
      ss = qs[S-1];
      for (int i = S - 1; i > 0; i--) begin qr[i] = qr[i-1]; qs[i] = qs[i-1]; end
      qr[0] = REQ;
      qs[0] = start;
      cur = exp_freq();
      m_load = !m_busy && rs;
      if (m_load) begin sh_f = DDS_freq; sh_s = DDS_delta_freq; sh_r = DDS_delta_rate; end
      m_busy = m_load ? 1'b1 : (rs ? m_busy : 1'b0);
      m_ack = m_busy;
`ifdef DDS_PHASE_ACC_EN
      if ((ss && !m_ps) || !ss) m_phase = '0;
      else if (m_run) m_phase = m_phase + cur;
`endif
      if (ss && !m_ps) begin
        m_run = 1; m_base = sh_f; m_step = sh_s; m_rate = sh_r; n = 0;
      end else if (!ss) m_run = 0;
      else if (m_run) n++;
      m_ps = ss;
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      chk("ack", ACK, m_ack);
      chk("load", LOAD, m_load);
      chk("run", RUN, m_run);
      chk("freq_cur", FREQ_CUR, exp_freq());
      chk("phase", PHASE, m_phase);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic wait_sig(input string nm, input bit sel, input bit val);
    int k = 0;
    while (((sel ? RUN : ACK) !== val) && k < 40) begin @(negedge CLK); k++; end
    chk(nm, sel ? RUN : ACK, val);
  endtask

  task automatic send(input logic [FW-1:0] f, input logic [FW-1:0] s, input logic [RW-1:0] r);
    DDS_freq = f; DDS_delta_freq = s; DDS_delta_rate = r;
    REQ = 1;
    wait_sig("send_ack_hi", 0, 1);
    REQ = 0;
    wait_sig("send_ack_lo", 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk("reset_ack", ACK, 0);
    chk("reset_run", RUN, 0);
    chk("reset_freq", FREQ_CUR, 0);
    #2 RESET = 0;
    tick(2);
    // handshake timing: REQ raised between edge 0 and edge 1
    DDS_freq = 48'h001000000000; DDS_delta_freq = 48'h100000; DDS_delta_rate = 32'h100;
    REQ = 1;
    tick(1); chk("hs_ack_e1", ACK, 0);
    tick(1); chk("hs_ack_e2", ACK, 0); chk("hs_load_e2", LOAD, 0);
    tick(1); chk("hs_ack_e3", ACK, 1); chk("hs_load_e3", LOAD, 1);
    tick(1); chk("hs_load_e4", LOAD, 0); chk("hs_ack_e4", ACK, 1);
    REQ = 0;
    tick(2); chk("hs_ackfall_e2", ACK, 1);
    tick(1); chk("hs_ackfall_e3", ACK, 0);
    // ramp
    start = 1;
    wait_sig("ramp_run", 1, 1);
    chk("ramp_base", FREQ_CUR, 48'h001000000000);
    tick(255); chk("ramp_255", FREQ_CUR, 48'h001000000000);
    tick(1); chk("ramp_256", FREQ_CUR, 48'h001000100000);
    tick(256); chk("ramp_512", FREQ_CUR, 48'h001000200000);
    // mid-run capture leaves the active ramp alone
    send(48'h002000000000, 48'h100000, 32'h100);
    chk("midrun_old_base", FREQ_CUR[FW-1:24], 24'h001000);
    start = 0;
    wait_sig("midrun_stop", 1, 0);
    chk("midrun_stop_freq", FREQ_CUR, 0);
    start = 1;
    wait_sig("midrun_restart", 1, 1);
    chk("midrun_new_base", FREQ_CUR, 48'h002000000000);
    tick(20);
    // wrap
    start = 0;
    wait_sig("wrap_stop", 1, 0);
    send(48'hFFFFFFFFFFF0, 48'h20, 32'd1);
    start = 1;
    wait_sig("wrap_run", 1, 1);
    chk("wrap_base", FREQ_CUR, 48'hFFFFFFFFFFF0);
    tick(1); chk("wrap_step1", FREQ_CUR, 48'h000000000010);
    tick(1); chk("wrap_step2", FREQ_CUR, 48'h000000000030);
    // zero rate freezes the ramp
    start = 0;
    wait_sig("rate0_stop", 1, 0);
    send(48'h003000000000, 48'h55, 32'd0);
    start = 1;
    wait_sig("rate0_run", 1, 1);
    tick(1000);
    chk("rate0_frozen", FREQ_CUR, 48'h003000000000);
    // capture and start edge on the same cycle use the fresh values
    start = 0;
    wait_sig("bypass_stop", 1, 0);
    tick(3);
    DDS_freq = 48'h004000000000; DDS_delta_freq = 48'h1; DDS_delta_rate = 32'd3;
    REQ = 1; start = 1;
    wait_sig("bypass_run", 1, 1);
    chk("bypass_ack", ACK, 1);
    chk("bypass_freq", FREQ_CUR, 48'h004000000000);
    tick(3); chk("bypass_step", FREQ_CUR, 48'h004000000001);
    REQ = 0;
    wait_sig("bypass_ack_lo", 0, 0);
    // asynchronous reset while holding ACK with the ramp running
    DDS_freq = 48'h00ABC0000000; REQ = 1;
    wait_sig("rst_hold_ack", 0, 1);
    #2 RESET = 1;
    #1;
    chk("rst_async_ack", ACK, 0);
    chk("rst_async_run", RUN, 0);
    chk("rst_async_freq", FREQ_CUR, 0);
    chk("rst_async_load", LOAD, 0);
    REQ = 0; start = 0;
    tick(2);
    #2 RESET = 0;
    tick(2);
    send(48'h005000000000, 48'h2, 32'd2);
    start = 1;
    wait_sig("post_rst_run", 1, 1);
    chk("post_rst_base", FREQ_CUR, 48'h005000000000);
    tick(4);
    chk("post_rst_step", FREQ_CUR, 48'h005000000004);
    start = 0;
    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
